// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM status encoding and memory-arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM model/controller each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Which cache currently owns the RAM port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of dcache completions seen while the icache is waiting.
// clr has priority over inc; the count sticks at MAX until cleared.
module arb_starve_counter #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(MAX));

  // Count register: synchronous clear on reset or clr, saturating increment.
  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch.
    if (!nRST)                count <= '0;
    else if (clr)             count <= '0;
    else if (inc && !at_max)  count <= count + W'(1);
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single RAM port between the icache and the dcache.
// Dcache has priority and keeps the port across back-to-back words; the
// icache is forced in after STARVE_MAX dcache completions while it waits.
// Optional counters: define CACHE_MEM_ARBITER_PERF_EN to add igrants, dgrants
// and forced.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef CACHE_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]       igrants,
  output logic [31:0]       dgrants,
  output logic [31:0]       forced
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t       state, next_state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_at_max;
  logic             d_req, access, d_done, i_done, force_i;

  assign d_req  = dREN | dWEN;
  assign access = (ramstate == ACCESS);
  assign d_done = (state == DGRANT) & access;
  assign i_done = (state == IGRANT) & access;

  // A completion that brings the count to STARVE_MAX hands the port to the icache.
  assign force_i = d_done & iREN &
                   (starve_at_max | (starve_cnt == CNT_W'(STARVE_MAX - 1)));

  arb_starve_counter #(.MAX(STARVE_MAX), .W(CNT_W)) u_starve (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (d_done & iREN & ~force_i),
    .clr    (d_done & (~iREN | force_i)),
    .count  (starve_cnt),
    .at_max (starve_at_max)
  );

  // Read data goes straight through; each cache only trusts it when its wait is low.
  assign iload = ramload;
  assign dload = ramload;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: state elements use non-blocking assignment so every flop samples pre-edge values.
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state selection.
  always_comb begin
    // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req)     next_state = DGRANT;
        else if (iREN) next_state = IGRANT;
      end
      DGRANT: begin
        if (access) begin
          if (force_i) next_state = IGRANT;
        end else if (!d_req) begin
          next_state = IDLE;
        end
      end
      IGRANT: begin
        if (access) begin
          if (d_req)      next_state = DGRANT;
          else if (iREN)  next_state = IGRANT;
          else            next_state = IDLE;
        end else if (!iREN) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // RAM port and wait muxing from the current owner.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~access;
      end
      IGRANT: begin
        ramREN   = iREN;
        ramaddr  = iaddr;
        iwait    = ~access;
      end
      default: ;
    endcase
  end

`ifdef CACHE_MEM_ARBITER_PERF_EN
  // Free-running completion and forced-switch counters (wrap at 2^32).
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      igrants <= '0;
      dgrants <= '0;
      forced  <= '0;
    end else begin
      if (i_done)  igrants <= igrants + 32'd1;
      if (d_done)  dgrants <= dgrants + 32'd1;
      if (force_i) forced  <= forced + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = i_done;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: completions go through a scoreboard
// queue checked by a negedge monitor; port-level values are checked inline.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [1:0]  ramstate;
`ifdef CACHE_MEM_ARBITER_PERF_EN
  logic [31:0] igrants, dgrants, forced;
  logic [31:0] dgrants_before;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.WORD_W(32), .STARVE_MAX(2)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef CACHE_MEM_ARBITER_PERF_EN
    ,
    .igrants  (igrants),
    .dgrants  (dgrants),
    .forced   (forced)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // Move to the falling edge, where outputs are stable.
  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic expect_done(input bit is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every low wait is a completion that must match the queue head.
  always @(negedge CLK) begin
    if (!iwait || !dwait) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", {30'd0, ~iwait, ~dwait}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("completion_owner", {31'd0, ~dwait}, {31'd0, e.is_d});
        check("completion_single", {31'd0, ~iwait & ~dwait}, 32'd0);
        if (e.is_d) check("dload", dload, e.data);
        else        check("iload", iload, e.data);
      end
    end
  end

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset and idle.
    repeat (2) nxt();
    nRST = 1'b1;
    at_neg();
    check("rst_iwait",   {31'd0, iwait},  32'd1);
    check("rst_dwait",   {31'd0, dwait},  32'd1);
    check("rst_ramREN",  {31'd0, ramREN}, 32'd0);
    check("rst_ramWEN",  {31'd0, ramWEN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);

    // Icache read of 0x40: one-cycle grant latency, two BUSY cycles, then ACCESS.
    nxt(); iREN = 1; iaddr = 32'h40; ramstate = BUSY;
    at_neg();
    check("i_latency_ramREN", {31'd0, ramREN}, 32'd0);
    nxt();
    at_neg();
    check("i_grant_ramREN",  {31'd0, ramREN}, 32'd1);
    check("i_grant_ramaddr", ramaddr, 32'h40);
    check("i_grant_iwait",   {31'd0, iwait}, 32'd1);
    nxt();
    at_neg();
    check("i_busy_iwait", {31'd0, iwait}, 32'd1);
    nxt(); ramstate = ACCESS; ramload = 32'hDEADBEEF; expect_done(1'b0, 32'hDEADBEEF);
    at_neg();
    nxt(); iREN = 0; ramstate = FREE;
    at_neg();
    check("i_after_iwait",  {31'd0, iwait},  32'd1);
    check("i_after_ramREN", {31'd0, ramREN}, 32'd0);
    nxt();
    at_neg();
    check("idle_ramaddr", ramaddr, 32'd0);

    // Simultaneous requests: dcache wins, two-word fill, then forced icache grant.
    nxt(); dREN = 1; iREN = 1; daddr = 32'h100; iaddr = 32'h80; ramstate = FREE;
    at_neg();
    nxt();
    at_neg();
    check("d_first_ramaddr", ramaddr, 32'h100);
    check("d_first_ramREN",  {31'd0, ramREN}, 32'd1);
    check("d_first_iwait",   {31'd0, iwait},  32'd1);
    nxt(); ramstate = ACCESS; ramload = 32'h11111111; expect_done(1'b1, 32'h11111111);
    at_neg();
    nxt(); daddr = 32'h104; ramload = 32'h22222222; expect_done(1'b1, 32'h22222222);
    at_neg();
    check("d_word2_ramaddr", ramaddr, 32'h104);
    nxt(); dREN = 0; ramstate = BUSY;
    at_neg();
    check("forced_ramaddr", ramaddr, 32'h80);
    check("forced_ramREN",  {31'd0, ramREN}, 32'd1);
    nxt(); ramstate = ACCESS; ramload = 32'h33333333; expect_done(1'b0, 32'h33333333);
    at_neg();
    nxt(); iREN = 0; ramstate = FREE;
    at_neg();
    nxt();
    at_neg();

    // Dcache write with both enables high, three ERROR cycles before ACCESS.
    nxt(); dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h5;
    at_neg();
    nxt();
    at_neg();
    check("wr_ramWEN",   {31'd0, ramWEN}, 32'd1);
    check("wr_ramREN",   {31'd0, ramREN}, 32'd0);
    check("wr_ramstore", ramstore, 32'h5);
    check("wr_ramaddr",  ramaddr, 32'h200);
`ifdef CACHE_MEM_ARBITER_PERF_EN
    dgrants_before = dgrants;
`endif
    for (int k = 0; k < 3; k++) begin
      nxt(); ramstate = ERROR;
      at_neg();
      check("err_dwait", {31'd0, dwait}, 32'd1);
    end
    nxt(); ramstate = ACCESS; ramload = 32'hCAFEF00D; expect_done(1'b1, 32'hCAFEF00D);
    at_neg();
    nxt(); dREN = 0; dWEN = 0; ramstate = FREE;
    at_neg();
    check("wr_after_dwait", {31'd0, dwait}, 32'd1);
`ifdef CACHE_MEM_ARBITER_PERF_EN
    check("perf_dgrants_delta", dgrants - dgrants_before, 32'd1);
`endif
    nxt();
    at_neg();

    // Reset in the middle of a dcache transfer.
    nxt(); dREN = 1; daddr = 32'h300; ramstate = BUSY;
    at_neg();
    nxt();
    at_neg();
    check("mid_ramaddr", ramaddr, 32'h300);
    nxt(); nRST = 0;
    at_neg();
    nxt(); nRST = 1; dREN = 0;
    at_neg();
    check("mid_rst_dwait",   {31'd0, dwait},  32'd1);
    check("mid_rst_ramREN",  {31'd0, ramREN}, 32'd0);
    check("mid_rst_ramaddr", ramaddr, 32'd0);

    nxt();
    at_neg();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
